// File: rtl/cgol_pkg.sv
// Shared Game-of-Life definitions: loader state encoding, LFSR taps, counter width.
package cgol_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE,
    RUN
  } state_t;

  localparam int unsigned GENBITS_DEFAULT = 16;

  // Maximal-length Fibonacci tap masks (bit W-1 always set, so the register is invertible).
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0E08;
      13:      lfsr_taps = 32'h0000_1C80;
      14:      lfsr_taps = 32'h0000_3802;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_D008;
      default: lfsr_taps = 32'h3 << (width - 2);
    endcase
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// WIDTH-bit Fibonacci LFSR, seeded all-ones on synchronous active-low reset.
module lfsr_gen
  import cgol_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  localparam logic [31:0]      TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  // Shift left, feeding back the parity of the tapped bits.
  always_ff @(posedge ph1) begin
    if (!reset) begin
      q <= '1;
    end else if (step) begin
      q <= {q[WIDTH-2:0], ^(q & TAPS)};
    end
  end

endmodule

// File: rtl/seed_loader.sv
// Loads the initial board into the generation state file, then enables the
// generation controller and counts completed generations.
// Optional random-board load: define SEED_LOADER_LFSR_EN.
module seed_loader
  import cgol_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned REGBITS = 3,
  parameter int unsigned GENBITS = GENBITS_DEFAULT
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               load_req,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               gen_tick,
`ifdef SEED_LOADER_LFSR_EN
  input  logic               rand_req,
`endif
  output logic               we,
  output logic [REGBITS-1:0] waddr,
  output logic [WIDTH-1:0]   wdata,
  output logic               load_done,
  output logic               run,
  output logic [GENBITS-1:0] gen_count
);

  state_t             state;
  logic [REGBITS-1:0] idx;
  logic               row_wr;
  logic [WIDTH-1:0]   row_data;
  logic               rand_start;

`ifdef SEED_LOADER_LFSR_EN
  logic             rand_mode;
  logic [WIDTH-1:0] lfsr_q;

  lfsr_gen #(.WIDTH(WIDTH)) u_lfsr (
    .ph1   (ph1),
    .reset (reset),
    .step  (state == LOAD && rand_mode),
    .q     (lfsr_q)
  );

  assign rand_start = rand_req && !load_req && (state == IDLE || state == RUN);
  assign in_ready   = (state == LOAD) && !rand_mode;
  assign row_wr     = (state == LOAD) && (rand_mode || in_valid);
  assign row_data   = rand_mode ? lfsr_q : in_data;
`else
  assign rand_start = 1'b0;
  assign in_ready   = (state == LOAD);
  assign row_wr     = in_valid && in_ready;
  assign row_data   = in_data;
`endif

  // Load sequencer with registered write port, status and generation counter.
  // A restart never cancels the write issued by a row taken in the same cycle.
  always_ff @(posedge ph1) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      load_done <= 1'b0;
      run       <= 1'b0;
      gen_count <= '0;
`ifdef SEED_LOADER_LFSR_EN
      rand_mode <= 1'b0;
`endif
    end else begin
      we        <= row_wr;
      load_done <= 1'b0;
      if (row_wr) begin
        waddr <= idx;
        wdata <= row_data;
      end
      if (state == RUN && gen_tick && gen_count != '1) begin
        gen_count <= gen_count + GENBITS'(1);
      end
      if (load_req || rand_start) begin
        state <= LOAD;
        idx   <= '0;
        run   <= 1'b0;
`ifdef SEED_LOADER_LFSR_EN
        rand_mode <= rand_start;
`endif
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            if (row_wr) begin
              idx <= idx + REGBITS'(1);
              if (idx == '1) begin
                state <= FLUSH;
              end
            end
          end
          FLUSH: begin
            state     <= DONE;
            load_done <= 1'b1;
            gen_count <= '0;
          end
          DONE: begin
            state <= RUN;
            run   <= 1'b1;
          end
          RUN: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seed_loader.sv
// Directed bench for seed_loader (second instance with GENBITS=4 for saturation).
module tb_seed_loader;

  logic       ph1;
  logic       reset;
  logic       load_req;
  logic       in_valid;
  logic [7:0] in_data;
  logic       gen_tick;
`ifdef SEED_LOADER_LFSR_EN
  logic       rand_req;
`endif

  logic        in_ready,   in_ready_4;
  logic        we,         we_4;
  logic [2:0]  waddr,      waddr_4;
  logic [7:0]  wdata,      wdata_4;
  logic        load_done,  load_done_4;
  logic        run,        run_4;
  logic [15:0] gen_count;
  logic [3:0]  gen_count_4;

  int n_cmp = 0;
  int n_bad = 0;

  seed_loader #(.WIDTH(8), .REGBITS(3), .GENBITS(16)) dut (
    .ph1       (ph1),
    .reset     (reset),
    .load_req  (load_req),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .gen_tick  (gen_tick),
`ifdef SEED_LOADER_LFSR_EN
    .rand_req  (rand_req),
`endif
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .load_done (load_done),
    .run       (run),
    .gen_count (gen_count)
  );

  seed_loader #(.WIDTH(8), .REGBITS(3), .GENBITS(4)) dut4 (
    .ph1       (ph1),
    .reset     (reset),
    .load_req  (load_req),
    .in_valid  (in_valid),
    .in_ready  (in_ready_4),
    .in_data   (in_data),
    .gen_tick  (gen_tick),
`ifdef SEED_LOADER_LFSR_EN
    .rand_req  (rand_req),
`endif
    .we        (we_4),
    .waddr     (waddr_4),
    .wdata     (wdata_4),
    .load_done (load_done_4),
    .run       (run_4),
    .gen_count (gen_count_4)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] last_d;
    int         k;
    logic       v;

    reset    = 1'b0;
    load_req = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    gen_tick = 1'b1;
`ifdef SEED_LOADER_LFSR_EN
    rand_req = 1'b0;
`endif

    // Reset dominates load_req, in_valid and gen_tick.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_we", we, 0);
      chk("rst_run", run, 0);
      chk("rst_gen_count", gen_count, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_load_done", load_done, 0);
    end
    reset    = 1'b1;
    load_req = 1'b0;
    in_valid = 1'b0;
    gen_tick = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 0);
    chk("idle_we", we, 0);

    // Basic back-to-back load 0x01..0x80.
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 8'h01 << i;
      in_data = d;
      chk("basic_in_ready", in_ready, 1);
      tick();
      chk("basic_we", we, 1);
      chk("basic_waddr", waddr, 32'(i));
      chk("basic_wdata", wdata, 32'(d));
      chk("basic_no_done", load_done, 0);
    end
    in_valid = 1'b0;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_run", run, 0);
    tick();
    chk("done_pulse", load_done, 1);
    chk("done_we", we, 0);
    chk("done_run", run, 0);
    chk("done_gen_count", gen_count, 0);
    tick();
    chk("run_done_low", load_done, 0);
    chk("run_high", run, 1);
    chk("run_we", we, 0);

    // Generation counting and saturation at GENBITS=4.
    for (int i = 0; i < 5; i++) begin
      gen_tick = 1'b1;
      tick();
      gen_tick = 1'b0;
      tick();
    end
    chk("gen5", gen_count, 5);
    chk("gen5_4", gen_count_4, 5);
    gen_tick = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("gen20", gen_count, 20);
    chk("gen20_sat4", gen_count_4, 15);
    tick();
    gen_tick = 1'b0;
    chk("gen21", gen_count, 21);
    chk("gen21_sat4", gen_count_4, 15);

    // Restart from RUN drops run at the same edge.
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("restart_run", run, 0);
    chk("restart_in_ready", in_ready, 1);
    chk("restart_we", we, 0);
    gen_tick = 1'b1;
    tick();
    gen_tick = 1'b0;
    chk("load_ignores_tick", gen_count, 21);

    // Bursty valid: addresses contiguous, data in order.
    k = 0;
    last_d = 8'h80;
    for (int c = 0; c < 64 && k < 8; c++) begin
      v = (c == 0 || c == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
      d = 8'h3C ^ 8'(k * 8'h11);
      in_valid = v;
      in_data  = d;
      tick();
      if (v) begin
        chk("burst_we", we, 1);
        chk("burst_waddr", waddr, 32'(k));
        chk("burst_wdata", wdata, 32'(d));
        last_d = d;
        k++;
      end else begin
        chk("burst_gap_we", we, 0);
        chk("burst_gap_hold", wdata, 32'(last_d));
      end
    end
    in_valid = 1'b0;
    chk("burst_count", k, 8);
    tick();
    chk("burst_done", load_done, 1);
    chk("burst_gen_cleared", gen_count, 0);
    tick();
    chk("burst_run", run, 1);

    // Mid-load restart together with the 4th beat.
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = 8'h11 * 8'(i + 1);
      in_data = d;
      tick();
      chk("mid_waddr", waddr, 32'(i));
      chk("mid_wdata", wdata, 32'(d));
    end
    in_data  = 8'h44;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("mid_restart_we", we, 1);
    chk("mid_restart_waddr", waddr, 3);
    chk("mid_restart_wdata", wdata, 32'h44);
    chk("mid_restart_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      d = 8'h50 + 8'(i);
      in_data = d;
      tick();
      chk("reload_waddr", waddr, 32'(i));
      chk("reload_wdata", wdata, 32'(d));
      chk("reload_no_done", load_done, 0);
    end
    in_valid = 1'b0;
    tick();
    chk("reload_done", load_done, 1);
    tick();
    chk("reload_run", run, 1);

    // Reset in the middle of a load.
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick();
    chk("pre_rst_we", we, 1);
    reset = 1'b0;
    tick();
    chk("midrst_we", we, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_waddr", waddr, 0);
    chk("midrst_wdata", wdata, 0);
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("post_rst_idle", in_ready, 0);

`ifdef SEED_LOADER_LFSR_EN
    // Random load from IDLE: 8 consecutive LFSR rows, first 0xFF, none zero.
    rand_req = 1'b1;
    in_valid = 1'b1;
    tick();
    rand_req = 1'b0;
    d = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk("rand_in_ready", in_ready, 0);
      tick();
      chk("rand_we", we, 1);
      chk("rand_waddr", waddr, 32'(i));
      chk("rand_wdata", wdata, 32'(d));
      chk("rand_nonzero", (wdata != 8'h00), 1);
      d = {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    end
    in_valid = 1'b0;
    tick();
    chk("rand_done", load_done, 1);
    tick();
    chk("rand_run", run, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
